io_bus_arbiter: RTL
===================

# io_bus_arbiter

Two-master arbiter and transaction sequencer for the IO device port (ce/we/addr/wtData/rdData). Sits between the CPU memory-stage IO path (master 0) and a secondary requester such as a debug loader or DMA (master 1). Each master gets a req/ack handshake, and the IO device sees exactly one registered, single-cycle access per transaction. Supports round-robin fairness and an optional per-master bus lock for read-modify-write sequences on LED/key registers.

## Interface
- No parameters; all widths are fixed at 32-bit address and data.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  transaction request; held with fields stable until the matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read (matches `IOWrite`/`IOUnWrite` encoding)
- m0_lock, m1_lock  in  1  keep ownership after this transaction
- m0_addr, m1_addr  in  32  IO address
- m0_wdata, m1_wdata  in  32  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  32  read result; valid in the ack cycle and held until the next ack to that master
- io_ce  out  1  IO chip enable (`IOEnable` when active)
- io_we  out  1  IO write enable
- io_addr  out  32  IO address
- io_wdata  out  32  IO write data
- io_rdata  in  32  IO read data (combinational from the device)

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: samples requests.
  - If the lock is held, only the owner is eligible.
  - Otherwise the round-robin rule picks the winner (see Configuration).
  - The winner's we/addr/wdata are registered into the io_* outputs, `gnt` is set to the winner, and the FSM moves to BUSY.
  - With no eligible request, the FSM stays in IDLE.
- BUSY:
  - io_ce=1 for exactly this cycle.
  - On a read, io_rdata is captured into mN_rdata of the granted master at the end of the cycle.
  - On a write, the granted mN_rdata is loaded with 0.
  - Next state is DONE.
- DONE:
  - io_ce=0; mN_ack=1 for the granted master only.
  - Lock update: if the granted master's lock=1 in this cycle, lock_held=1 and owner=gnt; otherwise lock_held=0.
  - Next state is IDLE.
- Requests are ignored in BUSY and DONE. A master must drop req in the cycle after its ack, or it is re-arbitrated as a new transaction.
- Locked owner releases: if the owner's req is low in IDLE, lock_held clears and arbitration is open on the following cycle. The other master waits one extra cycle; it is never granted in that same IDLE cycle.
- `last` records the most recent granted master and updates on every grant.

## Timing
- Reset values:
  - FSM = IDLE; io_ce=0, io_we=0; io_addr/io_wdata=0.
  - m0_ack/m1_ack=0; m0_rdata/m1_rdata=0.
  - last=1, so master 0 wins the first tie; lock_held=0.
- Latency: req high at edge k (FSM in IDLE) → io_ce high in cycle k+1 → ack high in cycle k+2.
- Throughput: one transaction per 3 cycles at most.
- Simultaneous requests are resolved in a single IDLE cycle; the loser keeps req high and is granted after the current transaction.
- Reset mid-transaction (BUSY or DONE): abandoned, no ack issued, io_ce drops in the cycle after rst is sampled, and the lock clears.
- io_* outputs hold their values outside BUSY; only io_ce qualifies them.

## Configuration
- `IO_ARB_RR_EN` defined: round-robin. When both masters request, grant the master ≠ last. When one requests, grant it.
- Undefined: fixed priority, master 0 always wins ties. `last` is still tracked but unused. Lock behaviour is unchanged.

## Test plan
- Single read: m0 read addr=`Key` with io_rdata=32'h1 → io_ce high exactly 1 cycle, m0_ack at k+2, m0_rdata=32'h1, m1_ack stays 0.
- Write: m1 write addr=`Led`, wdata=32'h0000_A5A5 → io_we=1 and io_wdata=32'hA5A5 during BUSY, m1_ack at k+2, m1_rdata=0.
- Contention with RR_EN: both masters hold req continuously for 4 transactions → grants alternate m0,m1,m0,m1. Without the macro → m0,m0,m0,m0.
- Lock: m1 issues 3 back-to-back transactions with lock=1 while m0 also requests → all 3 go to m1. m1 then drops lock → next grant is m0.
- Reset mid-op: assert rst during BUSY → no ack; next cycle io_ce=0, FSM=IDLE, rdata=0. A new m0 request afterwards completes normally in 3 cycles.
- Held req: m0 keeps req high through its ack → a second transaction starts, ack at k+5 (not k+3).

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter and single-access sequencer for the IO port.
// Optional round-robin tie break with IO_ARB_RR_EN; default is fixed priority to m0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mN_req/we/lock        master N request, write flag, keep-ownership flag
//   mN_addr/wdata         master N address and write data
//   mN_ack/rdata          master N completion pulse and held read result
//   io_ce/we/addr/wdata   registered IO device access (qualified by io_ce)
//   io_rdata              combinational IO read data
module io_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        io_ce,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    logic   gnt;
    logic   last;
    logic   lock_held;
    logic   owner;

    logic   elig0;
    logic   elig1;
    logic   any;
    logic   win;

    // A held lock makes the non-owner ineligible; if the owner is not
    // requesting, nothing is eligible and the lock is released instead.
    always_comb begin
        elig0 = m0_req && (!lock_held || !owner);
        elig1 = m1_req && (!lock_held || owner);
        any   = elig0 || elig1;
        win   = elig1;
        if (elig0 && elig1) begin
`ifdef IO_ARB_RR_EN
            win = ~last;
`else
            win = 1'b0;
`endif
        end
    end

`ifndef IO_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            lock_held <= 1'b0;
            owner     <= 1'b0;
            io_ce     <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= 32'h0;
            io_wdata  <= 32'h0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rdata  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        gnt      <= win;
                        last     <= win;
                        io_we    <= win ? m1_we    : m0_we;
                        io_addr  <= win ? m1_addr  : m0_addr;
                        io_wdata <= win ? m1_wdata : m0_wdata;
                        io_ce    <= 1'b1;
                        state    <= BUSY;
                    end else if (lock_held) begin
                        lock_held <= 1'b0;
                    end
                end
                BUSY: begin
                    io_ce <= 1'b0;
                    if (gnt) begin
                        m1_rdata <= io_we ? 32'h0 : io_rdata;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= io_we ? 32'h0 : io_rdata;
                        m0_ack   <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (gnt ? m1_lock : m0_lock) begin
                        lock_held <= 1'b1;
                        owner     <= gnt;
                    end else begin
                        lock_held <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
